// File: rtl/noise_decision.sv
// ============================================================================
// Module   : noise_decision
// Purpose  : Adaptive-median noise decision; grows the window until the median
//            is not an impulse, then flags the centre pixel as noisy or clean.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module noise_decision #(
    parameter int DATA_WIDTH  = 8,
    parameter int LEVEL_WIDTH = 2,
    parameter int MAX_LEVEL   = 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_pixel,

    output logic                   stat_req,
    output logic [LEVEL_WIDTH-1:0] stat_level,
    input  logic                   stat_valid,
    input  logic [DATA_WIDTH-1:0]  stat_min,
    input  logic [DATA_WIDTH-1:0]  stat_med,
    input  logic [DATA_WIDTH-1:0]  stat_max,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_0,
    output logic [DATA_WIDTH-1:0]  out_1,
    output logic                   noiseF,
    output logic [LEVEL_WIDTH-1:0] out_level
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEVEL_WIDTH-1:0] C_MAX_LEVEL = LEVEL_WIDTH'(MAX_LEVEL);
    localparam logic [LEVEL_WIDTH-1:0] C_LEVEL_ONE = LEVEL_WIDTH'(1);

    state_t                 r_state;
    logic                   r_in_ready;
    logic                   r_stat_req;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [DATA_WIDTH-1:0]  r_pixel;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_0;
    logic [DATA_WIDTH-1:0]  r_out_1;
    logic                   r_noise;
    logic [LEVEL_WIDTH-1:0] r_out_level;

    logic w_stage_a;
    logic w_pixel_clean;
    logic w_last_level;

    // Stage A: median strictly between extremes means it is not an impulse.
    assign w_stage_a     = (stat_min < stat_med) && (stat_med < stat_max);
    assign w_pixel_clean = (stat_min < r_pixel) && (r_pixel < stat_max);
    assign w_last_level  = (r_level >= C_MAX_LEVEL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_stat_req  <= 1'b0;
            r_level     <= '0;
            r_pixel     <= '0;
            r_out_valid <= 1'b0;
            r_out_0     <= '0;
            r_out_1     <= '0;
            r_noise     <= 1'b0;
            r_out_level <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_pixel    <= in_pixel;
                        r_level    <= '0;
                        r_stat_req <= 1'b1;
                        r_in_ready <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end

                S_REQ: begin
                    r_stat_req <= 1'b0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (stat_valid) begin
                        if (w_stage_a) begin
                            r_noise     <= ~w_pixel_clean;
                            r_out_0     <= r_pixel;
                            r_out_1     <= stat_med;
                            r_out_level <= r_level;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (!w_last_level) begin
                            r_level    <= r_level + C_LEVEL_ONE;
                            r_stat_req <= 1'b1;
                            r_state    <= S_REQ;
                        end else begin
                            r_noise     <= 1'b1;
                            r_out_0     <= r_pixel;
                            r_out_1     <= stat_med;
                            r_out_level <= C_MAX_LEVEL;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Return to IDLE without accepting, so a new pixel waits one cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                    r_stat_req <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign stat_req   = r_stat_req;
    assign stat_level = r_level;
    assign out_valid  = r_out_valid;
    assign out_0      = r_out_0;
    assign out_1      = r_out_1;
    assign noiseF     = r_noise;
    assign out_level  = r_out_level;

endmodule

`default_nettype wire

// File: tb/tb_noise_decision.sv
// ============================================================================
// Module   : tb_noise_decision
// Purpose  : Directed self-checking bench for noise_decision.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_noise_decision;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       stat_req;
    logic [1:0] stat_level;
    logic       stat_valid;
    logic [7:0] stat_min, stat_med, stat_max;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_0, out_1;
    logic       noiseF;
    logic [1:0] out_level;

    int n_checks = 0;
    int n_errors = 0;
    int req_cnt  = 0;

    noise_decision #(.DATA_WIDTH(8), .LEVEL_WIDTH(2), .MAX_LEVEL(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .stat_req   (stat_req),
        .stat_level (stat_level),
        .stat_valid (stat_valid),
        .stat_min   (stat_min),
        .stat_med   (stat_med),
        .stat_max   (stat_max),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_0      (out_0),
        .out_1      (out_1),
        .noiseF     (noiseF),
        .out_level  (out_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (stat_req) req_cnt <= req_cnt + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a pixel; afterwards the bench sits in the REQ cycle.
    task automatic accept(input logic [7:0] pix);
        in_valid = 1'b1;
        in_pixel = pix;
        step();
        in_valid = 1'b0;
        check("accept_in_ready", in_ready, 0);
    endtask

    // From a REQ cycle: verify the request, answer it after 'dly' WAIT cycles.
    task automatic answer(input logic [1:0] lvl, input int dly,
                          input logic [7:0] mn, input logic [7:0] md, input logic [7:0] mx);
        check("req_pulse", stat_req, 1);
        check("req_level", stat_level, lvl);
        step();
        check("req_one_cycle", stat_req, 0);
        for (int i = 0; i < dly; i++) begin
            step();
            check("wait_hold", out_valid | stat_req, 0);
        end
        stat_valid = 1'b1;
        stat_min   = mn;
        stat_med   = md;
        stat_max   = mx;
        step();
        stat_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] o0, input logic [7:0] o1,
                              input logic nf, input logic [1:0] lvl);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_out0"},  out_0, o0);
        check({tag, "_out1"},  out_1, o1);
        check({tag, "_noise"}, noiseF, nf);
        check({tag, "_level"}, out_level, lvl);
        check({tag, "_busy"},  in_ready, 0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_pixel = 0; stat_valid = 0;
        stat_min = 0; stat_med = 0; stat_max = 0; out_ready = 0;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_outs", {out_valid, stat_req, noiseF, out_0, out_1, stat_level, out_level}, 0);
        rst = 1'b0;
        step();

        // Clean pixel, out_valid exactly at t+3
        accept(8'd100);
        answer(2'd0, 0, 8'd10, 8'd50, 8'd200);
        expect_out("clean", 8'd100, 8'd50, 1'b0, 2'd0);
        release_out();

        // Impulse pixel equal to max
        accept(8'd255);
        answer(2'd0, 0, 8'd0, 8'd60, 8'd255);
        expect_out("impulse", 8'd255, 8'd60, 1'b1, 2'd0);
        release_out();

        // Pixel equal to min is noise; stat_valid delayed in WAIT
        accept(8'd10);
        answer(2'd0, 3, 8'd10, 8'd50, 8'd200);
        expect_out("eqmin", 8'd10, 8'd50, 1'b1, 2'd0);
        release_out();

        // Window growth to level 1
        req_cnt = 0;
        accept(8'd0);
        answer(2'd0, 0, 8'd0, 8'd0, 8'd255);
        answer(2'd1, 0, 8'd5, 8'd40, 8'd250);
        expect_out("grow", 8'd0, 8'd40, 1'b1, 2'd1);
        check("grow_reqs", req_cnt, 2);
        release_out();

        // Exhausted levels
        req_cnt = 0;
        accept(8'd33);
        answer(2'd0, 0, 8'd0, 8'd0, 8'd9);
        answer(2'd1, 0, 8'd0, 8'd0, 8'd9);
        answer(2'd2, 0, 8'd0, 8'd7, 8'd7);
        expect_out("exhaust", 8'd33, 8'd7, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) step();
        check("exhaust_reqs", req_cnt, 3);
        check("exhaust_noreq", stat_req, 0);

        // Back-pressure with in_valid held high across completion
        in_valid = 1'b1;
        in_pixel = 8'd77;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("bp", 8'd33, 8'd7, 1'b1, 2'd2);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_idle_ready", in_ready, 1);
        check("bp_no_accept", stat_req, 0);
        check("bp_valid_low", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("bp_accept_next", stat_req, 1);
        answer(2'd0, 0, 8'd1, 8'd2, 8'd3);
        expect_out("bp2", 8'd77, 8'd2, 1'b1, 2'd0);
        release_out();

        // stat_valid while IDLE is ignored
        stat_valid = 1'b1; stat_min = 8'd1; stat_med = 8'd2; stat_max = 8'd3;
        step();
        step();
        stat_valid = 1'b0;
        check("idle_stat_ignored", {out_valid, stat_req}, 0);
        check("idle_ready", in_ready, 1);

        // Reset during WAIT
        accept(8'd100);
        step();
        rst = 1'b1;
        #1;
        check("wrst_in_ready", in_ready, 1);
        check("wrst_outs", {out_valid, stat_req, noiseF, out_0, out_1, stat_level, out_level}, 0);
        step();
        rst = 1'b0;
        stat_valid = 1'b1; stat_min = 8'd10; stat_med = 8'd50; stat_max = 8'd200;
        step();
        stat_valid = 1'b0;
        step();
        check("wrst_no_out", {out_valid, stat_req}, 0);
        check("wrst_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noise_decision.md
NOISE_DECISION -- requirements
Module: noise_decision

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of the pixel and statistic buses.
REQ-002 Parameter LEVEL_WIDTH, default 2, SHALL set the width of the window-level index.
REQ-003 Parameter MAX_LEVEL, default 2, SHALL set the last window level (0=3x3, 1=5x5, 2=7x7).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  centre pixel offered.
REQ-008 in_ready  output  1  block idle and accepting a pixel.
REQ-009 in_pixel  input  DATA_WIDTH  centre pixel zxy.
REQ-010 stat_req  output  1  one-cycle request for window statistics.
REQ-011 stat_level  output  LEVEL_WIDTH  window level requested.
REQ-012 stat_valid  input  1  statistics returned.
REQ-013 stat_min, stat_med, stat_max  input  DATA_WIDTH each  zmin, zmed, zmax of the requested window.
REQ-014 out_valid  output  1  decision available.
REQ-015 out_ready  input  1  downstream selector consumes the decision.
REQ-016 out_0  output  DATA_WIDTH  original pixel zxy.
REQ-017 out_1  output  DATA_WIDTH  median zmed of the final level.
REQ-018 noiseF  output  1  1 selects out_1, 0 selects out_0.
REQ-019 out_level  output  LEVEL_WIDTH  level at which the decision was made.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: when in_valid=1, the block SHALL latch in_pixel, set the level to 0 and go to REQ.
REQ-022 REQ: stat_req SHALL be 1 for exactly one cycle with stat_level equal to the current level; next state WAIT.
REQ-023 WAIT: the block SHALL hold until stat_valid=1, and stat_valid outside WAIT SHALL be ignored.
REQ-024 Stage A, on stat_valid in WAIT: if stat_min < stat_med < stat_max (strict, unsigned), the block SHALL perform Stage B.
- Stage B: noiseF = 0 if stat_min < pixel < stat_max, else noiseF = 1.
- out_1 = stat_med, out_0 = pixel, out_level = level; next state DONE.
REQ-025 If Stage A fails and level < MAX_LEVEL, the block SHALL increment the level and return to REQ.
REQ-026 If Stage A fails and level = MAX_LEVEL, the block SHALL set noiseF = 1, out_1 = stat_med, out_0 = pixel and out_level = MAX_LEVEL, and go to DONE.
REQ-027 DONE: out_valid SHALL be 1 and out_0, out_1, noiseF and out_level SHALL be stable until out_ready=1, then the block SHALL go to IDLE.
REQ-028 No pixel SHALL be accepted in the cycle in which out_ready completes.
REQ-029 Latency with stat_valid on the first WAIT cycle:
- accept at cycle t, stat_req at t+1, out_valid at t+3;
- each additional level SHALL add 2 cycles.
REQ-030 The level counter SHALL never exceed MAX_LEVEL, and at most MAX_LEVEL+1 requests SHALL be issued per pixel.
REQ-031 All comparisons SHALL be unsigned at DATA_WIDTH, and equality SHALL fail a strict comparison.

Reset
REQ-032 While rst=1, the state SHALL be IDLE and in_ready SHALL be 1.
REQ-033 While rst=1, out_valid, stat_req, noiseF, out_0, out_1, stat_level and out_level SHALL all be 0.
REQ-034 Reset asserted mid-operation SHALL abort the pixel, and any stat_valid that arrives later SHALL be ignored.

Verification
REQ-035 Clean pixel: pixel=100, L0 stats 10/50/200 -> noiseF=0, out_0=100, out_1=50, out_level=0, out_valid at t+3.
REQ-036 Impulse pixel: pixel=255, L0 stats 0/60/255 -> noiseF=1, out_1=60, out_level=0.
REQ-037 Window growth: pixel=0, L0 stats 0/0/255, L1 stats 5/40/250 -> requests at levels 0 then 1, noiseF=1, out_1=40, out_level=1.
REQ-038 Exhausted levels: all levels return min=med=0, L2 med=7 -> exactly 3 requests, noiseF=1, out_1=7, out_level=2.
REQ-039 Back-pressure: out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; after out_ready=1, next cycle in IDLE with in_ready=1.
REQ-040 Reset in WAIT: rst pulsed, then stat_valid=1 -> all outputs 0 immediately, no out_valid, in_ready=1.
